// File: rtl/adc128_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : adc128_pkg
// Purpose  : Shared constants and state encoding for the ADC128S022 SPI
//            responder (frame geometry, channel count, FSM states).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package adc128_pkg;

   localparam int ADC128_FRAME_BITS = 16;  // SCLK cycles per conversion frame
   localparam int ADC128_DATA_BITS  = 12;  // conversion result width
   localparam int ADC128_LEAD_ZEROS = 4;   // zeros shifted ahead of D11
   localparam int ADC128_NUM_CH     = 8;   // analogue input channels
   localparam int ADC128_CNT_W      = $clog2(ADC128_FRAME_BITS);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,   // chip select high
      ST_ACTIVE = 1'b1    // chip select low, counting SCLK falling edges
   } adc128_state_t;

endpackage : adc128_pkg
`default_nettype wire

// File: rtl/adc128_spi_responder_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_input_sync
// Purpose  : Two-flop synchronizer for an asynchronous SPI pin, plus
//            rise/fall detection against a one-cycle-delayed copy of the
//            synchronized level.
// Ports    : clk_40MHz - system clock
//            reset     - asynchronous active-high reset
//            i_async   - raw pin input
//            o_rise    - one-cycle pulse on synchronized 0->1
//            o_fall    - one-cycle pulse on synchronized 1->0
// Revision : 1.0 - initial release
// ============================================================================
module spi_input_sync #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk_40MHz,
   input  logic reset,
   input  logic i_async,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_sync_d;

   always_ff @(posedge clk_40MHz or posedge reset) begin
      if (reset) begin
         r_meta   <= RESET_VAL;
         r_sync   <= RESET_VAL;
         r_sync_d <= RESET_VAL;
      end else begin
         r_meta   <= i_async;
         r_sync   <= r_meta;
         r_sync_d <= r_sync;
      end
   end

   // Edge pulses are combinational so the consumer acts one cycle after the
   // second synchronizer stage, giving a 3-cycle pin-to-register path.
   assign o_rise =  r_sync & ~r_sync_d;
   assign o_fall = ~r_sync &  r_sync_d;

endmodule : spi_input_sync
`default_nettype wire

// File: rtl/adc128_spi_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : adc128_spi_responder
// Purpose  : Emulates an ADC128S022 on an SPI bus. Decodes the 3-bit channel
//            address from DIN and returns a 16-bit frame (4 zeros + 12-bit
//            value) from an 8-entry channel register file. The address sent
//            in frame N selects the data returned in frame N+1. Optional ramp
//            mode increments the converted channel after every frame.
// Ports    : clk_40MHz, reset        - clock, async active-high reset
//            spi_cs_n/sclk/din       - SPI inputs from master (asynchronous)
//            spi_dout, spi_dout_oe   - serial data and pad drive enable
//            pattern_en              - ramp mode enable
//            ch_wr_en/addr/data      - channel register file write port
//            frame_done, frame_error - completion / truncation pulses
//            last_addr               - address of last completed frame
// Revision : 1.0 - initial release
// ============================================================================
module adc128_spi_responder
   import adc128_pkg::*;
#(
   parameter int ADDR_FIRST_EDGE = 3
) (
   input  logic        clk_40MHz,
   input  logic        reset,
   input  logic        spi_cs_n,
   input  logic        spi_sclk,
   input  logic        spi_din,
   output logic        spi_dout,
   output logic        spi_dout_oe,
   input  logic        pattern_en,
   input  logic        ch_wr_en,
   input  logic [2:0]  ch_wr_addr,
   input  logic [11:0] ch_wr_data,
   output logic        frame_done,
   output logic        frame_error,
   output logic [2:0]  last_addr
);

   // Rising edge n is seen while the falling-edge count is n-1.
   localparam logic [ADC128_CNT_W-1:0] c_addr_lo   = ADC128_CNT_W'(ADDR_FIRST_EDGE - 1);
   localparam logic [ADC128_CNT_W-1:0] c_addr_hi   = ADC128_CNT_W'(ADDR_FIRST_EDGE + 1);
   localparam logic [ADC128_CNT_W-1:0] c_last_edge = ADC128_CNT_W'(ADC128_FRAME_BITS - 1);
   localparam logic [ADC128_CNT_W-1:0] c_bit_top   = ADC128_CNT_W'(ADC128_FRAME_BITS - 2);

   adc128_state_t                 r_state;
   logic                          r_cs_meta, r_cs_sync;
   logic                          r_din_meta, r_din_sync;
   logic [ADC128_CNT_W-1:0]       r_edge_cnt;
   logic [ADC128_FRAME_BITS-1:0]  r_shift;
   logic [2:0]                    r_addr_shift;
   logic [2:0]                    r_conv_addr;
   logic                          r_frame_seen;
   logic [ADC128_DATA_BITS-1:0]   r_regfile [ADC128_NUM_CH];

   logic w_sclk_rise;
   logic w_sclk_fall;
   logic w_addr_window;
   logic w_frame_end;
   logic w_ramp_inc;

   spi_input_sync #(
      .RESET_VAL (1'b0)
   ) u_sclk_sync (
      .clk_40MHz (clk_40MHz),
      .reset     (reset),
      .i_async   (spi_sclk),
      .o_rise    (w_sclk_rise),
      .o_fall    (w_sclk_fall)
   );

   // CS idles high and DIN is only a level, so plain two-flop chains suffice.
   always_ff @(posedge clk_40MHz or posedge reset) begin
      if (reset) begin
         r_cs_meta  <= 1'b1;
         r_cs_sync  <= 1'b1;
         r_din_meta <= 1'b0;
         r_din_sync <= 1'b0;
      end else begin
         r_cs_meta  <= spi_cs_n;
         r_cs_sync  <= r_cs_meta;
         r_din_meta <= spi_din;
         r_din_sync <= r_din_meta;
      end
   end

   assign w_addr_window = (r_edge_cnt >= c_addr_lo) && (r_edge_cnt <= c_addr_hi);

   // A CS rise takes priority over any SCLK edge seen in the same cycle, so a
   // frame only completes while CS is still low.
   assign w_frame_end = (r_state == ST_ACTIVE) && !r_cs_sync && w_sclk_fall
                        && (r_edge_cnt == c_last_edge);
   assign w_ramp_inc  = w_frame_end && pattern_en;

   always_ff @(posedge clk_40MHz or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_edge_cnt   <= '0;
         r_shift      <= '0;
         r_addr_shift <= '0;
         r_conv_addr  <= '0;
         r_frame_seen <= 1'b0;
         last_addr    <= '0;
         spi_dout     <= 1'b0;
         spi_dout_oe  <= 1'b0;
         frame_done   <= 1'b0;
         frame_error  <= 1'b0;
      end else begin
         frame_done  <= 1'b0;
         frame_error <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               spi_dout    <= 1'b0;
               spi_dout_oe <= 1'b0;
               if (!r_cs_sync) begin
                  r_state      <= ST_ACTIVE;
                  r_edge_cnt   <= '0;
                  r_shift      <= {{ADC128_LEAD_ZEROS{1'b0}}, r_regfile[r_conv_addr]};
                  r_addr_shift <= '0;
                  r_frame_seen <= 1'b0;
                  spi_dout_oe  <= 1'b1;
               end
            end
            ST_ACTIVE: begin
               if (r_cs_sync) begin
                  r_state     <= ST_IDLE;
                  spi_dout    <= 1'b0;
                  spi_dout_oe <= 1'b0;
                  // A clean exit sits on a wrapped count after at least one
                  // completed frame; anything else was truncated.
                  if ((r_edge_cnt != '0) || !r_frame_seen)
                     frame_error <= 1'b1;
               end else begin
                  if (w_sclk_rise && w_addr_window)
                     r_addr_shift <= {r_addr_shift[1:0], r_din_sync};
                  if (w_sclk_fall) begin
                     r_edge_cnt <= r_edge_cnt + 1'b1;
                     if (w_frame_end) begin
                        spi_dout     <= 1'b0;
                        frame_done   <= 1'b1;
                        last_addr    <= r_addr_shift;
                        r_conv_addr  <= r_addr_shift;
                        r_frame_seen <= 1'b1;
                        // Continuous mode: next word comes from the address
                        // just decoded; the register read sees pre-update data.
                        r_shift      <= {{ADC128_LEAD_ZEROS{1'b0}}, r_regfile[r_addr_shift]};
                     end else begin
                        spi_dout <= r_shift[c_bit_top - r_edge_cnt];
                     end
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Channel register file: host write beats the ramp increment on a clash.
   always_ff @(posedge clk_40MHz or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ADC128_NUM_CH; i++)
            r_regfile[i] <= '0;
      end else begin
         for (int i = 0; i < ADC128_NUM_CH; i++) begin
            if (ch_wr_en && (ch_wr_addr == 3'(i)))
               r_regfile[i] <= ch_wr_data;
            else if (w_ramp_inc && (r_conv_addr == 3'(i)))
               r_regfile[i] <= r_regfile[i] + 1'b1;
         end
      end
   end

endmodule : adc128_spi_responder
`default_nettype wire
